operand_select_stage: RTL and testbench

- Parametrised, registered successor to the datapath immediate/register operand mux.
- Selects ALU operands A and B for the execute stage.
- Applies operand forwarding from the EX/MEM and MEM/WB stages.
- Extends the 16-bit immediate in one of three modes and registers the result behind a valid/ready pipeline handshake with stall and flush.
- Sits between the ID/EX boundary and the ALU.

---
 rtl/operand_select_stage.sv | 121 ++++++++++++
 tb/tb_operand_select_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_select_stage.sv
// Execute-stage operand select: forwards rs/rt, extends the immediate and
// registers operand A/B behind a single-entry valid/ready output register.
module operand_select_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int IMM_WIDTH      = 16,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rt_addr,
  input  logic [DATA_WIDTH-1:0]     in_rs_data,
  input  logic [DATA_WIDTH-1:0]     in_rt_data,
  input  logic [IMM_WIDTH-1:0]      in_immediate,
  input  logic [1:0]                in_imm_mode,
  input  logic                      in_select_imm,
  input  logic                      exmem_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_wr_addr,
  input  logic [DATA_WIDTH-1:0]     exmem_wr_data,
  input  logic                      memwb_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_wr_addr,
  input  logic [DATA_WIDTH-1:0]     memwb_wr_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_operand_a,
  output logic [DATA_WIDTH-1:0]     out_operand_b,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic [1:0]                out_fwd_a,
  output logic [1:0]                out_fwd_b
);

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEMWB   = 2'b01,
    FWD_EXMEM   = 2'b10
  } fwd_src_t;

  logic                  accept;
  logic [DATA_WIDTH-1:0] rs_fwd_data;
  logic [DATA_WIDTH-1:0] rt_fwd_data;
  fwd_src_t              rs_fwd_sel;
  fwd_src_t              rt_fwd_sel;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] imm_zero;
  logic [DATA_WIDTH-1:0] operand_b_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Younger EX/MEM result wins; register 0 is hard-wired and never forwarded.
  function automatic fwd_src_t fwd_pick(input logic [REG_ADDR_WIDTH-1:0] addr);
    if (addr == '0)
      return FWD_REGFILE;
    else if (exmem_wr_en && (exmem_wr_addr == addr))
      return FWD_EXMEM;
    else if (memwb_wr_en && (memwb_wr_addr == addr))
      return FWD_MEMWB;
    else
      return FWD_REGFILE;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fwd_data(input fwd_src_t sel,
                                                     input logic [DATA_WIDTH-1:0] rf_data);
    case (sel)
      FWD_EXMEM: return exmem_wr_data;
      FWD_MEMWB: return memwb_wr_data;
      default:   return rf_data;
    endcase
  endfunction

  always_comb begin
    rs_fwd_sel  = fwd_pick(in_rs_addr);
    rt_fwd_sel  = fwd_pick(in_rt_addr);
    rs_fwd_data = fwd_data(rs_fwd_sel, in_rs_data);
    rt_fwd_data = fwd_data(rt_fwd_sel, in_rt_data);
  end

  // Shift form keeps upper mode legal when DATA_WIDTH == 2*IMM_WIDTH.
  assign imm_zero = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, in_immediate};

  always_comb begin
    imm_ext = {{(DATA_WIDTH-IMM_WIDTH){in_immediate[IMM_WIDTH-1]}}, in_immediate};
    case (in_imm_mode)
      2'b01:   imm_ext = imm_zero;
      2'b10:   imm_ext = imm_zero << IMM_WIDTH;
      default: imm_ext = {{(DATA_WIDTH-IMM_WIDTH){in_immediate[IMM_WIDTH-1]}}, in_immediate};
    endcase
  end

  assign operand_b_next = in_select_imm ? imm_ext : rt_fwd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_operand_a  <= '0;
      out_operand_b  <= '0;
      out_store_data <= '0;
      out_fwd_a      <= 2'b00;
      out_fwd_b      <= 2'b00;
    end else begin
      // Data may load during a flush; it is hidden because valid drops.
      if (accept) begin
        out_operand_a  <= rs_fwd_data;
        out_operand_b  <= operand_b_next;
        out_store_data <= rt_fwd_data;
        out_fwd_a      <= rs_fwd_sel;
        out_fwd_b      <= rt_fwd_sel;
      end
      if (flush)
        out_valid <= 1'b0;
      else if (accept)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_select_stage.sv
// Self-checking bench for operand_select_stage: vector table driven through a
// scoreboard, plus reset, backpressure and flush sequences.
module tb_operand_select_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs_addr, in_rt_addr;
  logic [31:0] in_rs_data, in_rt_data;
  logic [15:0] in_immediate;
  logic [1:0]  in_imm_mode;
  logic        in_select_imm;
  logic        exmem_wr_en, memwb_wr_en;
  logic [4:0]  exmem_wr_addr, memwb_wr_addr;
  logic [31:0] exmem_wr_data, memwb_wr_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand_a, out_operand_b, out_store_data;
  logic [1:0]  out_fwd_a, out_fwd_b;

  always #5 clk = ~clk;

  operand_select_stage #(.DATA_WIDTH(32), .IMM_WIDTH(16), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_immediate(in_immediate), .in_imm_mode(in_imm_mode), .in_select_imm(in_select_imm),
    .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr), .exmem_wr_data(exmem_wr_data),
    .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr), .memwb_wr_data(memwb_wr_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_operand_a(out_operand_a), .out_operand_b(out_operand_b),
    .out_store_data(out_store_data), .out_fwd_a(out_fwd_a), .out_fwd_b(out_fwd_b)
  );

  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] rs_d, rt_d;
    logic [15:0] imm;
    logic [1:0]  mode;
    logic        sel;
    logic        ex_en;
    logic [4:0]  ex_a;
    logic [31:0] ex_d;
    logic        mw_en;
    logic [4:0]  mw_a;
    logic [31:0] mw_d;
    logic [31:0] exp_a, exp_b, exp_sd;
    logic [1:0]  exp_fa, exp_fb;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, sd;
    logic [1:0]  fa, fb;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];
  exp_t exp_cur;
  logic mv;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    in_rs_addr    = v.rs;    in_rt_addr    = v.rt;
    in_rs_data    = v.rs_d;  in_rt_data    = v.rt_d;
    in_immediate  = v.imm;   in_imm_mode   = v.mode;  in_select_imm = v.sel;
    exmem_wr_en   = v.ex_en; exmem_wr_addr = v.ex_a;  exmem_wr_data = v.ex_d;
    memwb_wr_en   = v.mw_en; memwb_wr_addr = v.mw_a;  memwb_wr_data = v.mw_d;
    exp_cur.a  = v.exp_a;  exp_cur.b  = v.exp_b;  exp_cur.sd = v.exp_sd;
    exp_cur.fa = v.exp_fa; exp_cur.fb = v.exp_fb;
  endtask

  // Called at a negedge with inputs already driven; advances one clock and
  // checks the DUT against the model at the following negedge.
  task automatic cycle(output bit acc);
    exp_t e;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!mv || out_ready)});
    acc = in_valid && (!mv || out_ready);
    if (rst) begin
      mv = 1'b0;
      sb.delete();
    end else begin
      if (flush) begin
        sb.delete();
      end else begin
        if (mv && out_ready && sb.size() > 0) begin
          e = sb.pop_front();
          $display("txn a=%h b=%h sd=%h fa=%b fb=%b", e.a, e.b, e.sd, e.fa, e.fb);
        end
        if (acc) sb.push_back(exp_cur);
      end
      mv = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : mv;
    end
    @(negedge clk);
    cyc++;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
    if (mv) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard: got empty want entry");
      end else begin
        chk("operand_a", out_operand_a, sb[0].a);
        chk("operand_b", out_operand_b, sb[0].b);
        chk("store_data", out_store_data, sb[0].sd);
        chk("fwd_a", {30'd0, out_fwd_a}, {30'd0, sb[0].fa});
        chk("fwd_b", {30'd0, out_fwd_b}, {30'd0, sb[0].fb});
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_a"}, out_operand_a, 32'd0);
    chk({tag, "_b"}, out_operand_b, 32'd0);
    chk({tag, "_sd"}, out_store_data, 32'd0);
    chk({tag, "_fa"}, {30'd0, out_fwd_a}, 32'd0);
    chk({tag, "_fb"}, {30'd0, out_fwd_b}, 32'd0);
  endtask

  initial begin
    bit acc;
    int tries;
    //          rs rt rs_d          rt_d          imm       md   sel ex_en ex_a ex_d          mw_en mw_a mw_d          exp_a         exp_b         exp_sd        fa     fb
    vecs[0] = '{3, 3, 32'h11112222, 32'h33334444, 16'hF000, 2'd0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h11112222, 32'hFFFFF000, 32'h33334444, 2'b00, 2'b00};
    vecs[1] = '{3, 3, 32'h11112222, 32'h33334444, 16'hF000, 2'd1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h11112222, 32'h0000F000, 32'h33334444, 2'b00, 2'b00};
    vecs[2] = '{3, 3, 32'h11112222, 32'h33334444, 16'hF000, 2'd2, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h11112222, 32'hF0000000, 32'h33334444, 2'b00, 2'b00};
    vecs[3] = '{3, 3, 32'h11112222, 32'h33334444, 16'h8001, 2'd3, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h11112222, 32'hFFFF8001, 32'h33334444, 2'b00, 2'b00};
    vecs[4] = '{3, 4, 32'h00000077, 32'd94035,    16'd4096, 2'd0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h00000077, 32'd94035,    32'd94035,    2'b00, 2'b00};
    vecs[5] = '{5, 6, 32'h55555555, 32'h66666666, 16'h0001, 2'd0, 0, 1, 5, 32'hAAAA0000, 1, 5, 32'h0000BBBB, 32'hAAAA0000, 32'h66666666, 32'h66666666, 2'b10, 2'b00};
    vecs[6] = '{5, 6, 32'h55555555, 32'h66666666, 16'h0001, 2'd0, 0, 0, 5, 32'hAAAA0000, 1, 5, 32'h0000BBBB, 32'h0000BBBB, 32'h66666666, 32'h66666666, 2'b01, 2'b00};
    vecs[7] = '{0, 0, 32'h12345678, 32'h9ABCDEF0, 16'h0001, 2'd0, 0, 1, 0, 32'hAAAA0000, 1, 0, 32'h0000BBBB, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 2'b00, 2'b00};
    vecs[8] = '{7, 8, 32'h00000007, 32'h00000008, 16'h8001, 2'd0, 1, 1, 8, 32'hCAFEBABE, 1, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFF8001, 32'hCAFEBABE, 2'b01, 2'b10};
    vecs[9] = '{9, 10, 32'h00000009, 32'h0000000A, 16'h7FFF, 2'd0, 0, 1, 10, 32'h0A0A0A0A, 0, 9, 32'hFFFFFFFF, 32'h00000009, 32'h0A0A0A0A, 32'h0A0A0A0A, 2'b00, 2'b10};

    // Reset held two cycles with in_valid asserted.
    mv = 1'b0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    apply(vecs[0]);
    @(posedge clk);
    @(negedge clk);
    chk_zero("reset1");
    cycle(acc);
    chk_zero("reset2");
    rst = 1'b0; in_valid = 1'b0;
    cycle(acc);

    // Vector table under intermittent downstream backpressure.
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i]);
      in_valid = 1'b1;
      tries = 0;
      do begin
        out_ready = (cyc % 3) != 2;
        cycle(acc);
        tries++;
      end while (!acc && tries < 20);
      if (!acc) begin
        total++; bad++;
        $display("FAIL accept_timeout: got none want accept of vector %0d", i);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(acc);
    cycle(acc);

    // Backpressure: X held three cycles while Y waits, then X drains and Y shows.
    apply(vecs[8]); in_valid = 1'b1; out_ready = 1'b1;
    cycle(acc);
    apply(vecs[9]); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle(acc);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a", out_operand_a, 32'hDEADBEEF);
    out_ready = 1'b1;
    cycle(acc);
    chk("bp_y_b", out_operand_b, 32'h0A0A0A0A);
    in_valid = 1'b0;
    cycle(acc);

    // Flush with a held operand set and a simultaneous accept.
    apply(vecs[0]); in_valid = 1'b1; out_ready = 1'b1;
    cycle(acc);
    apply(vecs[5]); flush = 1'b1;
    cycle(acc);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    cycle(acc);
    cycle(acc);

    // Reset while a transaction is held, then a fresh accept.
    apply(vecs[2]); in_valid = 1'b1; out_ready = 1'b0;
    cycle(acc);
    rst = 1'b1; in_valid = 1'b0;
    cycle(acc);
    chk_zero("midrst");
    rst = 1'b0; apply(vecs[4]); in_valid = 1'b1; out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    cycle(acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
